mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter between the core and a loader/debug port sharing one single-port
// data memory. Core has priority, but a loader that keeps losing is forced in
// after STARVE_LIMIT consecutive core grants. Read data returns one cycle
// after the grant and is steered to the requester that issued the read.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       core_req,
    input  logic       core_we,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_gnt,
    output logic       core_stall,
    output logic       core_rvalid,
    output logic [7:0] core_rdata,

    input  logic       ld_req,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_wdata,
    output logic       ld_gnt,
    output logic       ld_rvalid,
    output logic [7:0] ld_rdata,

    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        PRI_CORE = 1'b0,
        FORCE_LD = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_inc;
    logic            rd_valid;
    logic            rd_owner;      // 0 = core, 1 = loader
    logic [7:0]      core_hold;
    logic [7:0]      ld_hold;

    assign starve_inc = CW'(starve_cnt + CW'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PRI_CORE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: force the loader in on the grant that fills the starve count
    always_comb begin
        state_next = state;
        case (state)
            PRI_CORE: begin
                if (core_gnt && ld_req && (starve_inc == LIMIT)) begin
                    state_next = FORCE_LD;
                end
            end
            FORCE_LD: begin
                state_next = PRI_CORE;
            end
            default: begin
                state_next = PRI_CORE;
            end
        endcase
    end

    // Grant selection and memory request mux; everything held low in reset
    always_comb begin
        core_gnt   = 1'b0;
        ld_gnt     = 1'b0;
        core_stall = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 8'h00;
        if (!reset) begin
            case (state)
                PRI_CORE: begin
                    if (core_req) begin
                        core_gnt = 1'b1;
                    end else if (ld_req) begin
                        ld_gnt = 1'b1;
                    end
                end
                FORCE_LD: begin
                    if (ld_req) begin
                        ld_gnt = 1'b1;
                    end else if (core_req) begin
                        core_gnt = 1'b1;
                    end
                end
                default: begin
                    core_gnt = 1'b0;
                end
            endcase
            core_stall = core_req & ~core_gnt;
            mem_en     = core_gnt | ld_gnt;
            if (core_gnt) begin
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end else if (ld_gnt) begin
                mem_we    = ld_we;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
        end
    end

    // Count consecutive core grants taken while the loader waits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (ld_gnt || !ld_req) begin
            starve_cnt <= '0;
        end else if (core_gnt && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_inc;
        end
    end

    // Remember who issued the read so the returning data goes to them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_valid <= (core_gnt & ~core_we) | (ld_gnt & ~ld_we);
            rd_owner <= ld_gnt;
        end
    end

    assign core_rvalid = rd_valid & ~rd_owner;
    assign ld_rvalid   = rd_valid &  rd_owner;

    // Hold the last delivered read data for each port between responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_hold <= 8'h00;
            ld_hold   <= 8'h00;
        end else begin
            if (core_rvalid) begin
                core_hold <= mem_rdata;
            end
            if (ld_rvalid) begin
                ld_hold <= mem_rdata;
            end
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : core_hold;
    assign ld_rdata   = ld_rvalid   ? mem_rdata : ld_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grant/bus records
// and expected read responses; a negedge monitor pops and compares.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata;
    logic       core_gnt, core_stall, core_rvalid;
    logic [7:0] core_rdata;
    logic       ld_req, ld_we;
    logic [7:0] ld_addr, ld_wdata;
    logic       ld_gnt, ld_rvalid;
    logic [7:0] ld_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous-read single-port memory
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic       cg;
        logic       lg;
        logic       stall;
        logic       en;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } gexp_t;

    typedef struct {
        logic       owner;
        logic [7:0] data;
        int         due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;

    // One arbitration cycle: drive requests, push expected grant and response
    task automatic step(
        input logic       cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
        input logic       lr, input logic lw, input logic [7:0] la, input logic [7:0] ld,
        input logic       ecg, input logic elg,
        input logic [7:0] erd, input logic resp
    );
        gexp_t e;
        @(posedge clk); #1;
        reset = 1'b0;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        ld_req   = lr; ld_we   = lw; ld_addr   = la; ld_wdata   = ld;
        e.cg = ecg; e.lg = elg; e.stall = cr & ~ecg; e.en = ecg | elg;
        e.we = 1'b0; e.addr = 8'h00; e.wdata = 8'h00;
        if (ecg) begin e.we = cw; e.addr = ca; e.wdata = cd; end
        if (elg) begin e.we = lw; e.addr = la; e.wdata = ld; end
        gq.push_back(e);
        if (resp && ecg && !cw) rq.push_back('{owner: 1'b0, data: erd, due: cyc + 1});
        if (resp && elg && !lw) rq.push_back('{owner: 1'b1, data: erd, due: cyc + 1});
    endtask

    // Assert reset for n cycles with both requesters active
    task automatic reset_pulse(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h82; core_wdata = 8'hFF;
        ld_req   = 1'b1; ld_we   = 1'b1; ld_addr   = 8'h20; ld_wdata   = 8'hEE;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor
    gexp_t      me;
    rexp_t      mr;
    logic       exp_cv, exp_lv;
    logic [7:0] hold_c = 8'h00;
    logic [7:0] hold_l = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ({core_gnt, core_stall, core_rvalid, core_rdata, ld_gnt, ld_rvalid, ld_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata} != '0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d: cg=%b cs=%b crv=%b crd=%h lg=%b lrv=%b lrd=%h en=%b we=%b a=%h wd=%h, required all 0",
                         cyc, core_gnt, core_stall, core_rvalid, core_rdata, ld_gnt, ld_rvalid,
                         ld_rdata, mem_en, mem_we, mem_addr, mem_wdata);
            end
            hold_c = 8'h00;
            hold_l = 8'h00;
            while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        end else begin
            if (gq.size() > 0) begin
                me = gq.pop_front();
                checks++;
                if ({core_gnt, ld_gnt, core_stall, mem_en, mem_we, mem_addr, mem_wdata} !=
                    {me.cg, me.lg, me.stall, me.en, me.we, me.addr, me.wdata}) begin
                    errors++;
                    $display("FAIL grant cyc=%0d: got cg=%b lg=%b st=%b en=%b we=%b a=%h wd=%h, required cg=%b lg=%b st=%b en=%b we=%b a=%h wd=%h",
                             cyc, core_gnt, ld_gnt, core_stall, mem_en, mem_we, mem_addr, mem_wdata,
                             me.cg, me.lg, me.stall, me.en, me.we, me.addr, me.wdata);
                end
            end
            exp_cv = (rq.size() > 0) && (rq[0].due == cyc) && !rq[0].owner;
            exp_lv = (rq.size() > 0) && (rq[0].due == cyc) &&  rq[0].owner;
            checks++;
            if ({core_rvalid, ld_rvalid} != {exp_cv, exp_lv}) begin
                errors++;
                $display("FAIL rvalid cyc=%0d: got core=%b ld=%b, required core=%b ld=%b",
                         cyc, core_rvalid, ld_rvalid, exp_cv, exp_lv);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mr = rq.pop_front();
                if (mr.owner) hold_l = mr.data;
                else          hold_c = mr.data;
            end
            checks++;
            if (core_rdata != hold_c || ld_rdata != hold_l) begin
                errors++;
                $display("FAIL rdata cyc=%0d: got core=%h ld=%h, required core=%h ld=%h",
                         cyc, core_rdata, ld_rdata, hold_c, hold_l);
            end
        end
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h82] = 8'h5A;
        mem_rdata  = 8'h00;
        reset = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        ld_req   = 1'b0; ld_we   = 1'b0; ld_addr   = 8'h00; ld_wdata   = 8'h00;
        #1;
        reset_pulse(2);

        // Core-only read of 0x82 returns 0x5A next cycle
        step(1, 0, 8'h82, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A, 1);
        idle();

        // Loader writes 0x33 to 0x10, core reads it back
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h33, 0, 1, 8'h00, 0);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h33, 1);
        idle();

        // Continuous contention: C,C,C,C,L twice, back-to-back
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 0, 1, 8'h00, 1);
            else            step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 1, 0, 8'h5A, 1);
        end

        // Loader drops after two starved cycles; count restarts
        step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 1, 0, 8'h5A, 1);
        step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 1, 0, 8'h5A, 1);
        step(1, 0, 8'h82, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 0, 1, 8'h00, 1);
            else        step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 1, 0, 8'h5A, 1);
        end

        // Reset right after a read grant: the response is dropped
        step(1, 0, 8'h82, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        reset_pulse(1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 0, 1, 8'h00, 1);
            else        step(1, 0, 8'h82, 8'h00, 1, 1, 8'h20, 8'h77, 1, 0, 8'h5A, 1);
        end

        // Loader read returns the data it wrote earlier
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 8'h77, 1);
        idle();
        idle();
        @(posedge clk); #1;
        @(negedge clk); #1;

        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain: got grant_q=%0d read_q=%0d, required 0 and 0", gq.size(), rq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
